// File: rtl/cfg_reg_pkg.sv
// rtl/cfg_reg_pkg.sv - register-map types shared by the P2P filter status path
package cfg_reg_pkg;

   parameter int STAT_CNT_W = 32;

   // One packet decision from the filter match logic
   typedef struct packed {
      logic valid;
      logic rule0_hit;
      logic rule1_hit;
      logic drop;
   } stat_evt_t;

   // Snapshot seen by the register slave; every field is a zero-extended counter
   typedef struct packed {
      logic [31:0] drop_cnt;
      logic [31:0] rule1_cnt;
      logic [31:0] rule0_cnt;
      logic [31:0] total_cnt;
   } status_reg_t;

   typedef enum logic [1:0] {IDLE, CAPTURE, ACK, WAIT_LOW} snap_state_t;

endpackage

// File: rtl/p2p_stat_counter.sv
// rtl/p2p_stat_counter.sv - single event counter with clear and wrap or saturate (P2P_STAT_SATURATE_EN)
module p2p_stat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o,
   output logic [CNT_W-1:0] count_next_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] inc_ext;

   assign inc_ext = {{(CNT_W-1){1'b0}}, inc_i};

`ifdef P2P_STAT_SATURATE_EN
   // Next value including this cycle's increment, pinned at all-ones
   always_comb begin
      count_d = count_q;
      if (count_q != {CNT_W{1'b1}}) begin
         count_d = count_q + inc_ext;
      end
   end
`else
   // Next value including this cycle's increment, modulo 2^CNT_W
   always_comb begin
      count_d = count_q + inc_ext;
   end
`endif

   // Clear wins over the increment; the caller snapshots count_next_o on that edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o      = count_q;
   assign count_next_o = count_d;

endmodule

// File: rtl/p2p_status_counters.sv
// rtl/p2p_status_counters.sv - P2P filter decision counters with coherent snapshot handshake (P2P_STAT_SATURATE_EN selects saturation)
import cfg_reg_pkg::*;

module p2p_status_counters #(
   parameter int CNT_W    = STAT_CNT_W,
   parameter int EVT_PIPE = 1
) (
   input  logic        axis_aclk,
   input  logic        axis_aresetn,
   input  logic        evt_valid,
   input  logic        evt_rule0_hit,
   input  logic        evt_rule1_hit,
   input  logic        evt_drop,
   input  logic        snap_req,
   input  logic        snap_clr,
   output logic        snap_ack,
   output status_reg_t status_o
);

   stat_evt_t        evt_in;
   stat_evt_t        evt_cnt;
   logic [3:0]       inc;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_q    [4];
   logic [CNT_W-1:0] cnt_next [4];

   snap_state_t      state_q;
   logic             clr_q;
   logic             ack_q;
   status_reg_t      status_q;

   assign evt_in = '{valid: evt_valid, rule0_hit: evt_rule0_hit,
                     rule1_hit: evt_rule1_hit, drop: evt_drop};

   generate
      if (EVT_PIPE == 1) begin : g_pipe
         stat_evt_t evt_q;
         // Retime the event bus once before it fans out to the counters
         always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
            if (!axis_aresetn) begin
               evt_q <= '0;
            end else begin
               evt_q <= evt_in;
            end
         end
         assign evt_cnt = evt_q;
      end else begin : g_nopipe
         assign evt_cnt = evt_in;
      end
   endgenerate

   // Index 0 total, 1 rule0, 2 rule1, 3 drop; flags only count on a valid event
   assign inc = {evt_cnt.drop, evt_cnt.rule1_hit, evt_cnt.rule0_hit, 1'b1}
                & {4{evt_cnt.valid}};

   // Clearing on the capture edge moves the coincident event into the snapshot only
   assign cnt_clr = (state_q == CAPTURE) && clr_q;

   generate
      for (genvar i = 0; i < 4; i++) begin : g_cnt
         p2p_stat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i        (axis_aclk),
            .rst_ni       (axis_aresetn),
            .inc_i        (inc[i]),
            .clr_i        (cnt_clr),
            .count_o      (cnt_q[i]),
            .count_next_o (cnt_next[i])
         );
      end
   endgenerate

   logic unused_cnt;
   assign unused_cnt = ^{cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]};

   // Snapshot handshake: capture all fields on one edge, pulse ack, wait for request release
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q  <= IDLE;
         clr_q    <= 1'b0;
         ack_q    <= 1'b0;
         status_q <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (snap_req) begin
                  state_q <= CAPTURE;
                  clr_q   <= snap_clr;
               end
            end
            CAPTURE: begin
               status_q.total_cnt <= 32'(cnt_next[0]);
               status_q.rule0_cnt <= 32'(cnt_next[1]);
               status_q.rule1_cnt <= 32'(cnt_next[2]);
               status_q.drop_cnt  <= 32'(cnt_next[3]);
               ack_q   <= 1'b1;
               state_q <= ACK;
            end
            ACK: begin
               state_q <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!snap_req) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign snap_ack = ack_q;
   assign status_o = status_q;

endmodule

// File: tb/tb_p2p_status_counters.sv
// tb/tb_p2p_status_counters.sv - randomized bench with a reference model for p2p_status_counters
import cfg_reg_pkg::*;

module tb_p2p_status_counters;

   localparam int CNT_W    = 8;
   localparam int EVT_PIPE = 1;
   localparam int MAXV     = (1 << CNT_W) - 1;

   logic        clk;
   logic        axis_aresetn;
   logic        evt_valid;
   logic        evt_rule0_hit;
   logic        evt_rule1_hit;
   logic        evt_drop;
   logic        snap_req;
   logic        snap_clr;
   logic        snap_ack;
   status_reg_t status_o;

   int          n_tests;
   int          n_fail;

   bit          evt_mode;
   bit          m_clr;
   int          m_cnt [4];
   int          exp_f [4];
   logic [3:0]  m_pipe [$];

   p2p_status_counters #(.CNT_W(CNT_W), .EVT_PIPE(EVT_PIPE)) dut (
      .axis_aclk     (clk),
      .axis_aresetn  (axis_aresetn),
      .evt_valid     (evt_valid),
      .evt_rule0_hit (evt_rule0_hit),
      .evt_rule1_hit (evt_rule1_hit),
      .evt_drop      (evt_drop),
      .snap_req      (snap_req),
      .snap_clr      (snap_clr),
      .snap_ack      (snap_ack),
      .status_o      (status_o)
   );

   initial clk = 1'b0;
   always #2 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int bump(input int c);
`ifdef P2P_STAT_SATURATE_EN
      return (c >= MAXV) ? MAXV : c + 1;
`else
      return (c + 1) % (MAXV + 1);
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_cnt[i] = 0;
         exp_f[i] = 0;
      end
      m_pipe.delete();
   endtask

   task automatic set_evt(input bit v, input bit r0, input bit r1, input bit d);
      evt_valid     = v;
      evt_rule0_hit = r0;
      evt_rule1_hit = r1;
      evt_drop      = d;
   endtask

   // One clock: optional random event, then apply the spec's counting rules to the model
   task automatic tick(input bit cap);
      logic [3:0] e;
      logic [3:0] a;
      if (evt_mode) begin
         set_evt($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      end
      e = {evt_valid, evt_rule0_hit, evt_rule1_hit, evt_drop};
      @(posedge clk);
      m_pipe.push_back(e);
      if (m_pipe.size() > EVT_PIPE) begin
         a = m_pipe.pop_front();
         if (a[3]) begin
            m_cnt[0] = bump(m_cnt[0]);
            if (a[2]) m_cnt[1] = bump(m_cnt[1]);
            if (a[1]) m_cnt[2] = bump(m_cnt[2]);
            if (a[0]) m_cnt[3] = bump(m_cnt[3]);
         end
      end
      if (cap) begin
         for (int i = 0; i < 4; i++) exp_f[i] = m_cnt[i];
         if (m_clr) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         end
      end
      #1;
   endtask

   task automatic chk_snap(input string tag);
      chk({tag, ".total"}, status_o.total_cnt, exp_f[0]);
      chk({tag, ".rule0"}, status_o.rule0_cnt, exp_f[1]);
      chk({tag, ".rule1"}, status_o.rule1_cnt, exp_f[2]);
      chk({tag, ".drop"},  status_o.drop_cnt,  exp_f[3]);
   endtask

   // Full request/ack handshake; ack is due two cycles after the request is raised
   task automatic do_snap(input string tag, input bit clr, input bit drop_cap);
      snap_req = 1'b1;
      snap_clr = clr;
      m_clr    = clr;
      if (drop_cap) set_evt(1, 0, 0, 1);
      tick(0);
      if (drop_cap) set_evt(0, 0, 0, 0);
      chk({tag, ".ack_early"}, snap_ack, 0);
      tick(1);
      chk({tag, ".ack"}, snap_ack, 1);
      chk_snap(tag);
      snap_req = 1'b0;
      snap_clr = 1'b0;
      tick(0);
      chk({tag, ".ack_pulse"}, snap_ack, 0);
      tick(0);
   endtask

   initial begin
      logic [2:0] t1 [10];
      int         acks;

      n_tests  = 0;
      n_fail   = 0;
      evt_mode = 1'b0;
      m_clr    = 1'b0;
      axis_aresetn = 1'b0;
      snap_req = 1'b0;
      snap_clr = 1'b0;
      set_evt(0, 0, 0, 0);
      model_reset();
      repeat (3) tick(0);
      axis_aresetn = 1'b1;
      model_reset();
      tick(0);

      chk("reset.ack", snap_ack, 0);
      chk("reset.status_lo", status_o[63:0], 0);
      chk("reset.status_hi", status_o[127:64], 0);

      // 1: ten mixed events
      t1 = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b110,
             3'b001, 3'b001, 3'b001, 3'b001};
      for (int i = 0; i < 10; i++) begin
         set_evt(1, t1[i][2], t1[i][1], t1[i][0]);
         tick(0);
      end
      set_evt(0, 0, 0, 0);
      repeat (2) tick(0);
      do_snap("t1", 0, 0);
      chk("t1.total_c", status_o.total_cnt, 10);
      chk("t1.rule0_c", status_o.rule0_cnt, 4);
      chk("t1.rule1_c", status_o.rule1_cnt, 3);
      chk("t1.drop_c",  status_o.drop_cnt,  4);
      do_snap("t1clr", 1, 0);

      // 2: drop coincident with a clearing capture
      do_snap("t2", 1, 1);
      chk("t2.drop_c", status_o.drop_cnt, 1);
      do_snap("t2post", 0, 0);
      chk("t2post.drop_c", status_o.drop_cnt, 0);

      // 6: flags without evt_valid
      set_evt(0, 1, 1, 1);
      repeat (5) tick(0);
      set_evt(0, 0, 0, 0);
      repeat (2) tick(0);
      do_snap("t6", 0, 0);
      chk("t6.total_c", status_o.total_cnt, 0);

      // 3: 257 events on an 8-bit counter
      for (int i = 0; i < 257; i++) begin
         set_evt(1, 0, 0, 0);
         tick(0);
      end
      set_evt(0, 0, 0, 0);
      repeat (2) tick(0);
      do_snap("t3", 1, 0);
`ifdef P2P_STAT_SATURATE_EN
      chk("t3.total_c", status_o.total_cnt, 255);
`else
      chk("t3.total_c", status_o.total_cnt, 1);
`endif
      do_snap("t3clr", 0, 0);

      // 4: request held for 20 cycles with events running
      evt_mode = 1'b1;
      acks     = 0;
      snap_req = 1'b1;
      m_clr    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(i == 1);
         if (snap_ack) acks++;
         if (i >= 1) chk("t4.stable", status_o.total_cnt, exp_f[0]);
      end
      snap_req = 1'b0;
      repeat (3) begin
         tick(0);
         if (snap_ack) acks++;
      end
      chk("t4.acks", acks, 1);
      do_snap("t4post", 0, 0);

      // 5: reset while the handshake is in flight
      repeat (6) tick(0);
      do_snap("t5pre", 0, 0);
      evt_mode = 1'b0;
      set_evt(0, 0, 0, 0);
      snap_req = 1'b1;
      tick(0);
      axis_aresetn = 1'b0;
      #0;
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         tick(0);
         if (snap_ack) acks++;
      end
      snap_req = 1'b0;
      axis_aresetn = 1'b1;
      model_reset();
      tick(0);
      if (snap_ack) acks++;
      chk("t5.no_ack", acks, 0);
      chk("t5.status_lo", status_o[63:0], 0);
      chk("t5.status_hi", status_o[127:64], 0);
      do_snap("t5post", 0, 0);

      // Randomized traffic with random snapshot/clear points
      evt_mode = 1'b1;
      for (int n = 0; n < 25; n++) begin
         repeat ($urandom_range(0, 15)) tick(0);
         do_snap("rnd", $urandom_range(0, 1) == 1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
